// File: rtl/snake_cmd_decoder.sv
// snake_cmd_decoder
//   Buffers the snake game core's 32-bit draw command stream in a show-ahead
//   FIFO. It reassembles two-word commands, scales logic cells to pixels and
//   presents one draw request at a time on a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cmd, cmd_vld      command word from the game core (no back-pressure)
//   req_vld, req_rdy  draw request handshake
//   req_type          0 = filled rectangle, 1 = character
//   req_x0/y0/x1/y1   rectangle corners (inclusive) or character position
//   req_color         fill colour or character foreground
//   req_bg, req_char, req_size  character background, code, scale
//   cmd_ovf           sticky: a command was dropped on a full FIFO
//
// Optional build macro SNAKE_CMD_DEC_STATS_EN adds:
//   drop_cnt          saturating count of discarded commands/pending words
//   fifo_hwm          FIFO occupancy high-water mark
module snake_cmd_decoder #(
    parameter int         FIFO_DEPTH  = 128,
    parameter int         FIFO_AW     = 7,
    parameter logic [4:0] H_LOGIC_MAX = 5'd31,
    parameter logic [4:0] V_LOGIC_MAX = 5'd23,
    parameter int         SPIXEL_PHY  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       cmd,
    input  logic              cmd_vld,
    output logic              req_vld,
    input  logic              req_rdy,
    output logic              req_type,
    output logic [9:0]        req_x0,
    output logic [8:0]        req_y0,
    output logic [9:0]        req_x1,
    output logic [8:0]        req_y1,
    output logic [7:0]        req_color,
    output logic [7:0]        req_bg,
    output logic [7:0]        req_char,
    output logic [3:0]        req_size,
    output logic              cmd_ovf
`ifdef SNAKE_CMD_DEC_STATS_EN
    ,
    output logic [7:0]        drop_cnt,
    output logic [FIFO_AW:0]  fifo_hwm
`endif
);

    typedef enum logic [1:0] {IDLE, PEND, ISSUE} state_t;

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [9:0] SP_X    = 10'(SPIXEL_PHY);
    localparam logic [8:0] SP_Y    = 9'(SPIXEL_PHY);
    localparam logic [9:0] SP_M1_X = 10'(SPIXEL_PHY - 1);
    localparam logic [8:0] SP_M1_Y = 9'(SPIXEL_PHY - 1);

    // Constant-coefficient shift-add multiply by SPIXEL_PHY.
    function automatic logic [9:0] scale_x(input logic [4:0] v);
        logic [9:0] acc;
        acc = '0;
        for (int i = 0; i < 10; i++)
            if (SP_X[i]) acc = acc + ({5'b0, v} << i);
        return acc;
    endfunction

    function automatic logic [8:0] scale_y(input logic [4:0] v);
        logic [8:0] acc;
        acc = '0;
        for (int i = 0; i < 9; i++)
            if (SP_Y[i]) acc = acc + ({4'b0, v} << i);
        return acc;
    endfunction

    // ---------------- command FIFO ----------------
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               fifo_empty, fifo_full, push, pop;
    logic [31:0]        head;
    logic               ovf_reg;

    assign fifo_empty = (count_reg == '0);
    // Full uses the pre-pop count: a same-cycle pop does not make room.
    assign fifo_full  = (count_reg == DEPTH_C);
    assign push       = cmd_vld && !fifo_full;
    assign head       = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= cmd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (FIFO_AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (FIFO_AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (cmd_vld && fifo_full) ovf_reg <= 1'b1;
        end
    end

    // ---------------- head decode ----------------
    logic [9:0] sx_a, sx_b, ex_a, ex_b;
    logic [8:0] sy_a, sy_b, ey_a, ey_b;
    logic       cell_ok, rect_ok, line_ok, b_match;

    assign sx_a = scale_x(head[27:23]);
    assign sy_a = scale_y(head[22:18]);
    assign sx_b = scale_x(head[17:13]);
    assign sy_b = scale_y(head[12:8]);
    assign ex_a = sx_a + SP_M1_X;
    assign ey_a = sy_a + SP_M1_Y;
    assign ex_b = sx_b + SP_M1_X;
    assign ey_b = sy_b + SP_M1_Y;

    assign cell_ok = (head[27:23] <= H_LOGIC_MAX) && (head[22:18] <= V_LOGIC_MAX);
    assign rect_ok = (head[27:23] <= head[17:13]) && (head[22:18] <= head[12:8]) &&
                     (head[27:23] <= H_LOGIC_MAX) && (head[22:18] <= V_LOGIC_MAX) &&
                     (head[17:13] <= H_LOGIC_MAX) && (head[12:8]  <= V_LOGIC_MAX);

    // ---------------- FSM ----------------
    state_t     state_reg, state_next;
    logic [3:0] pend_op_reg;
    logic [9:0] pend_x_reg;
    logic [8:0] pend_y_reg;
    logic [7:0] pend_d_reg;
    logic       pend_latch, load;

    logic       n_type;
    logic [9:0] n_x0, n_x1;
    logic [8:0] n_y0, n_y1;
    logic [7:0] n_color, n_bg, n_char;
    logic [3:0] n_size;

    // Word B is recognised by bit 0 and must carry the pending word's opcode.
    assign b_match = (head[31:28] == pend_op_reg) && head[0];
    assign line_ok = (head[27:18] >= pend_x_reg) && (head[17:9] >= pend_y_reg);

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        load       = 1'b0;
        pend_latch = 1'b0;
        n_type     = 1'b0;
        n_x0       = '0;
        n_y0       = '0;
        n_x1       = '0;
        n_y1       = '0;
        n_color    = '0;
        n_bg       = '0;
        n_char     = '0;
        n_size     = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head[31:28])
                        4'h0: if (cell_ok) begin
                            load    = 1'b1;
                            n_x0    = sx_a;
                            n_y0    = sy_a;
                            n_x1    = ex_a;
                            n_y1    = ey_a;
                            n_color = head[17:10];
                        end
                        4'h1: if (rect_ok) begin
                            load    = 1'b1;
                            n_x0    = sx_a;
                            n_y0    = sy_a;
                            n_x1    = ex_b;
                            n_y1    = ey_b;
                            n_color = head[7:0];
                        end
                        // An orphan word B is popped and dropped.
                        4'h9, 4'ha: pend_latch = !head[0];
                        default: ;
                    endcase
                    if (load)       state_next = ISSUE;
                    if (pend_latch) state_next = PEND;
                end
            end
            PEND: begin
                if (!fifo_empty) begin
                    state_next = IDLE;
                    // A non-matching head is left in the FIFO to be decoded fresh.
                    if (b_match) begin
                        pop = 1'b1;
                        if (pend_op_reg == 4'ha) begin
                            load    = 1'b1;
                            n_type  = 1'b1;
                            n_x0    = pend_x_reg;
                            n_y0    = pend_y_reg;
                            n_char  = pend_d_reg;
                            n_color = head[27:20];
                            n_bg    = head[19:12];
                            n_size  = head[11:8];
                        end else if (line_ok) begin
                            load    = 1'b1;
                            n_x0    = pend_x_reg;
                            n_y0    = pend_y_reg;
                            n_x1    = head[27:18];
                            n_y1    = head[17:9];
                            n_color = pend_d_reg;
                        end
                        if (load) state_next = ISSUE;
                    end
                end
            end
            ISSUE: if (req_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pend_op_reg <= '0;
            pend_x_reg  <= '0;
            pend_y_reg  <= '0;
            pend_d_reg  <= '0;
            req_type    <= 1'b0;
            req_x0      <= '0;
            req_y0      <= '0;
            req_x1      <= '0;
            req_y1      <= '0;
            req_color   <= '0;
            req_bg      <= '0;
            req_char    <= '0;
            req_size    <= '0;
        end else begin
            state_reg <= state_next;
            if (pend_latch) begin
                pend_op_reg <= head[31:28];
                pend_x_reg  <= head[27:18];
                pend_y_reg  <= head[17:9];
                pend_d_reg  <= head[8:1];
            end
            if (load) begin
                req_type  <= n_type;
                req_x0    <= n_x0;
                req_y0    <= n_y0;
                req_x1    <= n_x1;
                req_y1    <= n_y1;
                req_color <= n_color;
                req_bg    <= n_bg;
                req_char  <= n_char;
                req_size  <= n_size;
            end
        end
    end

    assign req_vld = (state_reg == ISSUE);
    assign cmd_ovf = ovf_reg;

`ifdef SNAKE_CMD_DEC_STATS_EN
    // Popped without producing a request or a pending word, or a pending
    // word abandoned because the head did not complete it.
    logic       drop;
    logic [7:0] drop_cnt_reg;
    logic [FIFO_AW:0] hwm_reg;

    assign drop = (pop && !load && !pend_latch) ||
                  (state_reg == PEND && !fifo_empty && !pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
            hwm_reg      <= '0;
        end else begin
            if (drop && drop_cnt_reg != 8'hff) drop_cnt_reg <= drop_cnt_reg + 8'd1;
            if (count_reg > hwm_reg) hwm_reg <= count_reg;
        end
    end

    assign drop_cnt = drop_cnt_reg;
    assign fifo_hwm = hwm_reg;
`endif

endmodule

// File: tb/tb_snake_cmd_decoder.sv
// Directed testbench for snake_cmd_decoder: one-word and two-word decode,
// latency, malformed/orphan dropping, back-pressure, overflow and reset.
module tb_snake_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd = '0;
    logic        cmd_vld = 1'b0;
    logic        req_rdy = 1'b0;
    logic        req_vld, req_type, cmd_ovf;
    logic [9:0]  req_x0, req_x1;
    logic [8:0]  req_y0, req_y1;
    logic [7:0]  req_color, req_bg, req_char;
    logic [3:0]  req_size;
`ifdef SNAKE_CMD_DEC_STATS_EN
    logic [7:0]  drop_cnt;
    logic [7:0]  fifo_hwm;
`endif

    int total = 0;
    int bad   = 0;

    snake_cmd_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_type  (req_type),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_x1    (req_x1),
        .req_y1    (req_y1),
        .req_color (req_color),
        .req_bg    (req_bg),
        .req_char  (req_char),
        .req_size  (req_size),
        .cmd_ovf   (cmd_ovf)
`ifdef SNAKE_CMD_DEC_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .fifo_hwm  (fifo_hwm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rect(input string tag, input int x0, input int y0,
                            input int x1, input int y1, input int color);
        chk({tag, ".type"},  32'(req_type),  32'd0);
        chk({tag, ".x0"},    32'(req_x0),    32'(x0));
        chk({tag, ".y0"},    32'(req_y0),    32'(y0));
        chk({tag, ".x1"},    32'(req_x1),    32'(x1));
        chk({tag, ".y1"},    32'(req_y1),    32'(y1));
        chk({tag, ".color"}, 32'(req_color), 32'(color));
        $display("%s: req x0=%0d y0=%0d x1=%0d y1=%0d color=%0h", tag, req_x0, req_y0, req_x1, req_y1, req_color);
    endtask

    // Drive one word for one cycle; returns at the following negedge.
    task automatic push(input logic [31:0] w);
        cmd     = w;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd     = '0;
    endtask

    // Count requests seen over a fixed window (req_rdy assumed high).
    task automatic watch(input int cycles, output int nreq, output logic [9:0] x0,
                         output logic [8:0] y0, output logic [7:0] color);
        nreq = 0; x0 = '0; y0 = '0; color = '0;
        for (int c = 0; c < cycles; c++) begin
            if (req_vld) begin
                nreq++;
                x0 = req_x0; y0 = req_y0; color = req_color;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          nreq;
        logic [9:0]  wx0;
        logic [8:0]  wy0;
        logic [7:0]  wcol;

        // Reset
        req_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.vld",   32'(req_vld),   32'd0);
        chk("rst.ovf",   32'(cmd_ovf),   32'd0);
        chk("rst.x0",    32'(req_x0),    32'd0);
        chk("rst.y1",    32'(req_y1),    32'd0);
        chk("rst.color", 32'(req_color), 32'd0);
        chk("rst.type",  32'(req_type),  32'd0);
        $display("reset: vld=%0d ovf=%0d", req_vld, cmd_ovf);
        rst_n = 1'b1;
        @(negedge clk);

        // Cell fill, latency N+2, single-cycle handshake
        push({4'h0, 5'd3, 5'd2, 8'h0f, 10'b0});
        chk("cell.n1", 32'(req_vld), 32'd0);
        @(negedge clk);
        chk("cell.n2", 32'(req_vld), 32'd1);
        chk_rect("cell", 60, 40, 79, 59, 8'h0f);
        @(negedge clk);
        chk("cell.n3", 32'(req_vld), 32'd0);

        // Logic rectangle covering the whole screen
        push({4'h1, 5'd0, 5'd0, 5'd31, 5'd23, 8'hff});
        @(negedge clk);
        chk("rect.vld", 32'(req_vld), 32'd1);
        chk_rect("rect", 0, 0, 639, 479, 8'hff);
        @(negedge clk);

        // Line, back-to-back words, 2 cycles after word B
        push({4'h9, 10'd0, 9'd440, 8'h02, 1'b0});
        push({4'h9, 10'd639, 9'd442, 8'h02, 1'b1});
        chk("line.b1", 32'(req_vld), 32'd0);
        @(negedge clk);
        chk("line.b2", 32'(req_vld), 32'd1);
        chk_rect("line", 0, 440, 639, 442, 8'h02);
        @(negedge clk);

        // Character
        push({4'ha, 10'd619, 9'd450, 8'h30, 1'b0});
        push({4'ha, 8'h00, 8'hff, 4'h1, 8'h01});
        @(negedge clk);
        chk("char.vld",   32'(req_vld),   32'd1);
        chk("char.type",  32'(req_type),  32'd1);
        chk("char.x0",    32'(req_x0),    32'd619);
        chk("char.y0",    32'(req_y0),    32'd450);
        chk("char.char",  32'(req_char),  32'h30);
        chk("char.fg",    32'(req_color), 32'h00);
        chk("char.bg",    32'(req_bg),    32'hff);
        chk("char.size",  32'(req_size),  32'd1);
        $display("char: x0=%0d y0=%0d ch=%0h fg=%0h bg=%0h size=%0d", req_x0, req_y0, req_char, req_color, req_bg, req_size);
        @(negedge clk);

        // Orphan word B, then word A interrupted by a cell fill
        push({4'ha, 8'h00, 8'hff, 4'h1, 8'h01});
        push({4'h9, 10'd5, 9'd5, 8'h11, 1'b0});
        push({4'h0, 5'd1, 5'd1, 8'h33, 10'b0});
        watch(12, nreq, wx0, wy0, wcol);
        chk("orphan.nreq",  32'(nreq), 32'd1);
        chk("orphan.x0",    32'(wx0),  32'd20);
        chk("orphan.y0",    32'(wy0),  32'd20);
        chk("orphan.color", 32'(wcol), 32'h33);
`ifdef SNAKE_CMD_DEC_STATS_EN
        chk("orphan.drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        $display("orphan: nreq=%0d x0=%0d color=%0h", nreq, wx0, wcol);

        // Malformed commands: none may produce a request
        push({4'h0, 5'd0, 5'd24, 8'h01, 10'b0});
        push({4'h1, 5'd5, 5'd0, 5'd4, 5'd1, 8'h01});
        push({4'h1, 5'd0, 5'd0, 5'd1, 5'd24, 8'h01});
        push({4'h9, 10'd10, 9'd0, 8'h01, 1'b0});
        push({4'h9, 10'd9, 9'd5, 8'h01, 1'b1});
        push({4'h5, 28'h1});
        watch(12, nreq, wx0, wy0, wcol);
        chk("malformed.nreq", 32'(nreq), 32'd0);
        chk("malformed.ovf",  32'(cmd_ovf), 32'd0);
        $display("malformed: nreq=%0d", nreq);

        // Stalled renderer, 130 words: first goes to ISSUE, 128 stored, 1 dropped
        req_rdy = 1'b0;
        for (int i = 0; i < 130; i++)
            push({4'h0, 5'(i % 32), 5'((i / 32) % 24), 8'(i + 1), 10'b0});
        chk("ovf.flag",  32'(cmd_ovf),   32'd1);
        chk("ovf.vld",   32'(req_vld),   32'd1);
        chk("ovf.color", 32'(req_color), 32'd1);
        repeat (2) @(negedge clk);
        chk("stall.vld",   32'(req_vld),   32'd1);
        chk("stall.color", 32'(req_color), 32'd1);
        chk("stall.x1",    32'(req_x1),    32'd19);
`ifdef SNAKE_CMD_DEC_STATS_EN
        chk("ovf.hwm", 32'(fifo_hwm), 32'd128);
`endif
        $display("overflow: ovf=%0d vld=%0d color=%0h", cmd_ovf, req_vld, req_color);

        // Reset for one cycle abandons the request and empties the FIFO
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2.vld",   32'(req_vld),   32'd0);
        chk("rst2.ovf",   32'(cmd_ovf),   32'd0);
        chk("rst2.color", 32'(req_color), 32'd0);
`ifdef SNAKE_CMD_DEC_STATS_EN
        chk("rst2.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        req_rdy = 1'b1;
        watch(8, nreq, wx0, wy0, wcol);
        chk("rst2.empty", 32'(nreq), 32'd0);
        $display("reset2: vld=%0d ovf=%0d nreq=%0d", req_vld, cmd_ovf, nreq);

        // Fill again while stalled, then drain: 129 requests, last is word 128
        req_rdy = 1'b0;
        for (int i = 0; i < 130; i++)
            push({4'h0, 5'(i % 32), 5'((i / 32) % 24), 8'(i + 1), 10'b0});
        req_rdy = 1'b1;
        watch(300, nreq, wx0, wy0, wcol);
        chk("drain.nreq",  32'(nreq),    32'd129);
        chk("drain.color", 32'(wcol),    32'h81);
        chk("drain.x0",    32'(wx0),     32'd0);
        chk("drain.y0",    32'(wy0),     32'd80);
        chk("drain.ovf",   32'(cmd_ovf), 32'd1);
        $display("drain: nreq=%0d last color=%0h y0=%0d", nreq, wcol, wy0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
